// File: rtl/pwm_pkg.sv
// Shared state encoding and default geometry for the PWM generator.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_PERIOD = 255;

endpackage

// File: rtl/pwm_gen_if.sv
// Duty-programming and observation bus of the PWM generator.
// The master owns en/duty/duty_wr; the generator returns duty_ack, cnt and pwm.
interface pwm_gen_if #(
  parameter int WIDTH = pwm_pkg::DEF_WIDTH
);
  logic             en;
  logic [WIDTH-1:0] duty;
  logic             duty_wr;
  logic             duty_ack;
  logic [WIDTH-1:0] cnt;
  logic             pwm;

  modport master (
    output en, duty, duty_wr,
    input  duty_ack, cnt, pwm
  );

  modport slave (
    input  en, duty, duty_wr,
    output duty_ack, cnt, pwm
  );
endinterface

// File: rtl/pwm_counter.sv
// Period counter: counts 0..PERIOD while run_i is high, clears otherwise.
// tc_o flags the terminal count so the owner can detect the wrap edge.
module pwm_counter #(
  parameter int WIDTH  = pwm_pkg::DEF_WIDTH,
  parameter int PERIOD = pwm_pkg::DEF_PERIOD
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             run_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] TC = WIDTH'(PERIOD);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign tc_o  = (cnt_q == TC);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = '0;
    if (run_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  a_cnt_in_range : assert property (@(posedge ck) disable iff (!rst_n) cnt_q <= TC);

endmodule

// File: rtl/pwm_gen.sv
// PWM generator: registered pwm (1 cycle after cnt), duty double-buffered and swapped at wrap or in IDLE.
// Optional PWM_GEN_PERIOD_END_EN adds a period_end pulse in the cycle after each wrap.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic      ck,
  input  logic      rst_n,
  pwm_gen_if.slave  bus
`ifdef PWM_GEN_PERIOD_END_EN
  ,
  output logic      period_end
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             duty_ack_q, duty_ack_d;
  logic             pwm_q, pwm_d;

  logic             run_cnt;
  logic             cnt_tc;
  logic             wrap;
  logic             apply;
  logic [WIDTH-1:0] cnt_w;

  // Counting only continues while en stays high; a drop clears cnt at the same edge.
  assign run_cnt = (state_q == RUN) && bus.en;
  assign wrap    = run_cnt && cnt_tc;
  assign apply   = pend_vld_q && ((state_q == IDLE) || wrap);

  pwm_counter #(
    .WIDTH  (WIDTH),
    .PERIOD (PERIOD)
  ) u_counter (
    .ck    (ck),
    .rst_n (rst_n),
    .run_i (run_cnt),
    .cnt_o (cnt_w),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.en)  state_d = RUN;
      RUN:     if (!bus.en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The swap reads the old pending value, so a write on the swap edge stays pending.
  always_comb begin
    pwm_d       = run_cnt && (cnt_w < duty_act_q);
    duty_act_d  = apply ? duty_pend_q : duty_act_q;
    duty_ack_d  = apply;
    duty_pend_d = bus.duty_wr ? bus.duty : duty_pend_q;
    pend_vld_d  = bus.duty_wr ? 1'b1 : (apply ? 1'b0 : pend_vld_q);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      duty_act_q  <= '0;
      duty_pend_q <= '0;
      pend_vld_q  <= 1'b0;
      duty_ack_q  <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_act_q  <= duty_act_d;
      duty_pend_q <= duty_pend_d;
      pend_vld_q  <= pend_vld_d;
      duty_ack_q  <= duty_ack_d;
      pwm_q       <= pwm_d;
    end
  end

`ifdef PWM_GEN_PERIOD_END_EN
  logic period_end_q;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      period_end_q <= 1'b0;
    end else begin
      period_end_q <= wrap;
    end
  end

  assign period_end = period_end_q;
`endif

  assign bus.cnt      = cnt_w;
  assign bus.pwm      = pwm_q;
  assign bus.duty_ack = duty_ack_q;

  a_idle_cnt_zero : assert property (@(posedge ck) disable iff (!rst_n)
                                     (state_q == IDLE) |-> (cnt_w == '0));

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen (WIDTH=8, PERIOD=9): directed scenarios plus random traffic against a per-edge reference model.
module tb_pwm_gen;

  localparam int W = 8;
  localparam int P = 9;

  logic ck    = 1'b0;
  logic rst_n = 1'b1;

  pwm_gen_if #(.WIDTH(W)) bus ();

`ifdef PWM_GEN_PERIOD_END_EN
  logic period_end;
`endif

  pwm_gen #(
    .WIDTH  (W),
    .PERIOD (P)
  ) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PWM_GEN_PERIOD_END_EN
    ,
    .period_end (period_end)
`endif
  );

  always #5 ck = ~ck;

  int n_run  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Reference model: what each output must look like after an edge, from the block's rules.
  bit m_run;
  int m_cnt;
  bit m_pwm;
  int m_act;
  int m_pend;
  bit m_pvld;
  bit m_ack;
  bit m_pe;

  function void model_reset();
    m_run = 0; m_cnt = 0; m_pwm = 0; m_act = 0;
    m_pend = 0; m_pvld = 0; m_ack = 0; m_pe = 0;
  endfunction

  function void model_edge(bit e, bit w, int d);
    bit may_apply;
    may_apply = !m_run || (e && (m_cnt == P));
    m_ack = 0;
    m_pe  = 0;
    if (m_run && e) begin
      m_pwm = (m_cnt < m_act);
      m_pe  = (m_cnt == P);
      m_cnt = (m_cnt == P) ? 0 : m_cnt + 1;
    end else begin
      m_pwm = 0;
      m_cnt = 0;
    end
    m_run = e;
    if (m_pvld && may_apply) begin
      m_act  = m_pend;
      m_pvld = 0;
      m_ack  = 1;
    end
    if (w) begin
      m_pend = d & 255;
      m_pvld = 1;
    end
  endfunction

  task automatic step(input bit e, input bit w, input int d);
    bus.en      = e;
    bus.duty_wr = w;
    bus.duty    = d[W-1:0];
    @(posedge ck);
    if (!rst_n) model_reset();
    else        model_edge(e, w, d);
    @(negedge ck);
  endtask

  // Steps with en high at least once, until the model counter shows target.
  task automatic wait_cnt(input int target);
    int n = 0;
    do begin
      step(1, 0, 0);
      n++;
    end while (m_cnt != target && n < 25);
    if (m_cnt != target) begin
      n_run++; n_fail++;
      $display("FAIL wait_cnt: counter %0d not reached within %0d cycles", target, n);
    end
  endtask

  always @(negedge ck) begin
    if (chk_en && rst_n) begin
      n_run++;
      if (bus.cnt !== m_cnt[W-1:0]) begin
        n_fail++; $display("FAIL cnt @%0t: got %0d, expected %0d", $time, bus.cnt, m_cnt);
      end
      n_run++;
      if (bus.pwm !== m_pwm) begin
        n_fail++; $display("FAIL pwm @%0t: got %b, expected %b", $time, bus.pwm, m_pwm);
      end
      n_run++;
      if (bus.duty_ack !== m_ack) begin
        n_fail++; $display("FAIL duty_ack @%0t: got %b, expected %b", $time, bus.duty_ack, m_ack);
      end
`ifdef PWM_GEN_PERIOD_END_EN
      n_run++;
      if (period_end !== m_pe) begin
        n_fail++; $display("FAIL period_end @%0t: got %b, expected %b", $time, period_end, m_pe);
      end
`endif
    end
  end

  task automatic test_reset();
    bus.en = 0; bus.duty_wr = 0; bus.duty = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.cnt !== '0 || bus.pwm !== 1'b0 || bus.duty_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: cnt=%0d pwm=%b ack=%b, expected all 0", bus.cnt, bus.pwm, bus.duty_ack);
    end
    @(negedge ck);
    @(negedge ck);
    rst_n  = 1'b1;
    chk_en = 1;
    step(0, 0, 0);
    n_run++;
    if (bus.cnt !== '0 || bus.pwm !== 1'b0 || bus.duty_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: cnt=%0d pwm=%b ack=%b, expected all 0", bus.cnt, bus.pwm, bus.duty_ack);
    end
  endtask

  task automatic test_basic();
    int highs = 0;
    step(0, 1, 3);
    step(0, 0, 0);
    n_run++;
    if (bus.duty_ack !== 1'b1) begin
      n_fail++; $display("FAIL idle_ack: got %b, expected 1", bus.duty_ack);
    end
    step(0, 0, 0);
    n_run++;
    if (bus.duty_ack !== 1'b0) begin
      n_fail++; $display("FAIL idle_ack_single: got %b, expected 0", bus.duty_ack);
    end
    step(1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      step(1, 0, 0);
      highs += int'(bus.pwm);
    end
    n_run++;
    if (highs !== 9) begin
      n_fail++; $display("FAIL basic_duty3: %0d high cycles in 3 periods, expected 9", highs);
    end
  endtask

  task automatic test_extremes();
    int highs;
    step(1, 1, 0);
    wait_cnt(0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      highs += int'(bus.pwm);
    end
    n_run++;
    if (highs !== 0) begin
      n_fail++; $display("FAIL duty0_low: %0d high cycles, expected 0", highs);
    end
    step(1, 1, 10);
    wait_cnt(0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      highs += int'(bus.pwm);
    end
    n_run++;
    if (highs !== 20) begin
      n_fail++; $display("FAIL duty10_high: %0d high cycles, expected 20", highs);
    end
    step(1, 1, 200);
    wait_cnt(0);
    n_run++;
    if (bus.pwm !== 1'b1) begin
      n_fail++; $display("FAIL wrap_no_glitch: pwm=%b at wrap, expected 1", bus.pwm);
    end
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      highs += int'(bus.pwm);
    end
    n_run++;
    if (highs !== 20) begin
      n_fail++; $display("FAIL duty200_high: %0d high cycles, expected 20", highs);
    end
  endtask

  task automatic test_overwrite();
    int highs = 0;
    int acks  = 0;
    step(1, 1, 3);
    wait_cnt(0);
    for (int i = 0; i < 10; i++) begin
      step(1, (i == 4) || (i == 6), (i == 4) ? 7 : 5);
      highs += int'(bus.pwm);
      acks  += int'(bus.duty_ack);
    end
    n_run++;
    if (highs !== 3 || acks !== 1) begin
      n_fail++; $display("FAIL overwrite_cur: highs=%0d acks=%0d, expected highs=3 acks=1", highs, acks);
    end
    highs = 0; acks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0);
      highs += int'(bus.pwm);
      acks  += int'(bus.duty_ack);
    end
    n_run++;
    if (highs !== 5 || acks !== 0) begin
      n_fail++; $display("FAIL overwrite_next: highs=%0d acks=%0d, expected highs=5 acks=0", highs, acks);
    end
  endtask

  task automatic test_wrap_write();
    int highs = 0;
    wait_cnt(9);
    step(1, 1, 8);
    n_run++;
    if (bus.duty_ack !== 1'b0 || bus.cnt !== '0) begin
      n_fail++; $display("FAIL wrap_write_edge: ack=%b cnt=%0d, expected ack=0 cnt=0", bus.duty_ack, bus.cnt);
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0);
      highs += int'(bus.pwm);
    end
    n_run++;
    if (highs !== 5 || bus.duty_ack !== 1'b1) begin
      n_fail++; $display("FAIL wrap_write_old: highs=%0d ack=%b, expected highs=5 ack=1", highs, bus.duty_ack);
    end
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0);
      highs += int'(bus.pwm);
    end
    n_run++;
    if (highs !== 8) begin
      n_fail++; $display("FAIL wrap_write_new: %0d high cycles, expected 8", highs);
    end
  endtask

  task automatic test_en_drop();
    int highs = 0;
    wait_cnt(5);
    step(0, 0, 0);
    n_run++;
    if (bus.cnt !== '0 || bus.pwm !== 1'b0) begin
      n_fail++; $display("FAIL en_drop: cnt=%0d pwm=%b, expected cnt=0 pwm=0", bus.cnt, bus.pwm);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    n_run++;
    if (bus.cnt !== '0) begin
      n_fail++; $display("FAIL en_restart: cnt=%0d, expected 0", bus.cnt);
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0);
      highs += int'(bus.pwm);
    end
    n_run++;
    if (highs !== 8) begin
      n_fail++; $display("FAIL en_duty_held: %0d high cycles, expected 8", highs);
    end
  endtask

  task automatic test_async_reset();
    int highs = 0;
    int acks  = 0;
    int pes   = 0;
    wait_cnt(4);
    step(1, 1, 2);
    wait_cnt(6);
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.cnt !== '0 || bus.pwm !== 1'b0 || bus.duty_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: cnt=%0d pwm=%b ack=%b, expected all 0", bus.cnt, bus.pwm, bus.duty_ack);
    end
`ifdef PWM_GEN_PERIOD_END_EN
    n_run++;
    if (period_end !== 1'b0) begin
      n_fail++; $display("FAIL reset_period_end: got %b, expected 0", period_end);
    end
`endif
    model_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      step(1, 0, 0);
      highs += int'(bus.pwm);
      acks  += int'(bus.duty_ack);
`ifdef PWM_GEN_PERIOD_END_EN
      pes   += int'(period_end);
`endif
    end
    n_run++;
    if (acks !== 0 || highs !== 0) begin
      n_fail++; $display("FAIL reset_discard: acks=%0d highs=%0d, expected 0 and 0", acks, highs);
    end
`ifdef PWM_GEN_PERIOD_END_EN
    n_run++;
    if (pes !== 3) begin
      n_fail++; $display("FAIL period_end_rate: %0d pulses in 30 run cycles, expected 3", pes);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bit e, w;
      int d;
      e = ($urandom_range(0, 15) != 0);
      w = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 11);
      step(e, w, d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_overwrite();
    test_wrap_write();
    test_en_drop();
    test_async_reset();
    test_random();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
